// File: rtl/vecmat_add_seq.sv
// Job sequencer for a non-stallable adder tree feeding a result FIFO and RAM writer.
// Optional stall counter output enabled by defining VECMAT_ADD_SEQ_PERF_EN.
module vecmat_add_seq #(
  parameter int NUM_WORDS  = 32,
  parameter int TREE_LAT   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       tree_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
`ifdef VECMAT_ADD_SEQ_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + TREE_LAT + 1);
  localparam logic [CNT_W-1:0] NW = CNT_W'(NUM_WORDS);
  localparam logic [OCC_W-1:0] DEPTH_O = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    launch_cnt_q, launch_cnt_d;
  logic [CNT_W-1:0]    pop_cnt_q, pop_cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [TREE_LAT-1:0] pipe_q, pipe_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      fifo_cnt_q, fifo_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         mem_q [FIFO_DEPTH];

  logic [OCC_W-1:0]    inflight;
  logic [OCC_W-1:0]    occ;
  logic                in_ready_c;
  logic                out_valid_c;
  logic                launch;
  logic                push;
  logic                pop;

`ifdef VECMAT_ADD_SEQ_PERF_EN
  logic [15:0]         stall_q, stall_d;
`endif

  always_comb begin
    inflight = '0;
    for (int i = 0; i < TREE_LAT; i++) begin
      inflight = inflight + OCC_W'(pipe_q[i]);
    end
    // Reserve FIFO room for every product still inside the tree.
    occ         = inflight + OCC_W'(fifo_cnt_q);
    in_ready_c  = (state_q == RUN) && (launch_cnt_q < NW)
                  && (occ < DEPTH_O);
    out_valid_c = (fifo_cnt_q != '0);
    launch      = in_valid && in_ready_c;
    push        = pipe_q[TREE_LAT-1];
    pop         = out_valid_c && out_ready;
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    launch_cnt_d = launch_cnt_q + CNT_W'(launch);
    pop_cnt_d    = pop_cnt_q + CNT_W'(pop);
    pipe_d       = (pipe_q << 1) | TREE_LAT'(launch);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    fifo_cnt_d   = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          base_d       = base_addr;
          launch_cnt_d = '0;
          pop_cnt_d    = '0;
        end
      end
      RUN: begin
        if (launch_cnt_q == NW) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop_cnt_q == NW) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

`ifdef VECMAT_ADD_SEQ_PERF_EN
  always_comb begin
    stall_d = stall_q;
    if (busy_q && ((in_valid && !in_ready_c)
                   || (out_valid_c && !out_ready))
        && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    if (state_q == IDLE && start) stall_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      launch_cnt_q <= '0;
      pop_cnt_q    <= '0;
      base_q       <= '0;
      pipe_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      launch_cnt_q <= launch_cnt_d;
      pop_cnt_q    <= pop_cnt_d;
      base_q       <= base_d;
      pipe_q       <= pipe_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Storage is not reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= tree_sum;
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_c;
  assign out_data  = out_valid_c ? mem_q[rd_ptr_q] : '0;
  assign out_addr  = out_valid_c ? base_q + ADDR_W'(pop_cnt_q) : '0;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vecmat_add_seq.sv
// Randomized bench for vecmat_add_seq with a queue-based reference model.
module tb_vecmat_add_seq;
  localparam int NW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready;
  logic          out_valid, out_ready, busy, done;
  logic [AW-1:0] base_addr, out_addr;
  logic [15:0]   tree_sum, out_data;
`ifdef VECMAT_ADD_SEQ_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  vecmat_add_seq #(
    .NUM_WORDS(NW), .TREE_LAT(LAT),
    .FIFO_DEPTH(DEPTH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .in_valid(in_valid),
    .in_ready(in_ready), .tree_sum(tree_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done)
`ifdef VECMAT_ADD_SEQ_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // model: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
  int          mstate = 0;
  int          mlaunch = 0, mpop = 0, mbase = 0, mstall = 0;
  int          pq_age[$];
  logic [15:0] pq_val[$];
  logic [15:0] fq[$];

  int pop_addr[$];
  int n_done, n_launch;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit m_in_ready();
    return mstate == 1 && mlaunch < NW
           && (pq_age.size() + fq.size()) < DEPTH;
  endfunction

  task automatic model_update(input bit mir, input logic [15:0] prod);
    int lp, pp;
    bit bsy, pu, po;
    if (!reset) begin
      mstate = 0; mlaunch = 0; mpop = 0; mbase = 0; mstall = 0;
      pq_age.delete(); pq_val.delete(); fq.delete();
      return;
    end
    lp  = mlaunch;
    pp  = mpop;
    bsy = (mstate == 1 || mstate == 2);
    if (bsy && ((in_valid && !mir) || (fq.size() > 0 && !out_ready))
        && mstall < 65535) mstall++;
    po = fq.size() > 0 && out_ready;
    pu = pq_age.size() > 0 && pq_age[0] == LAT - 1;
    if (po) begin
      void'(fq.pop_front());
      mpop++;
    end
    if (pu) begin
      fq.push_back(pq_val[0]);
      void'(pq_val.pop_front());
      void'(pq_age.pop_front());
    end
    foreach (pq_age[i]) pq_age[i]++;
    if (in_valid && mir) begin
      pq_age.push_back(0);
      pq_val.push_back(prod);
      mlaunch++;
    end
    case (mstate)
      0: if (start) begin
        mstate = 1; mbase = int'(base_addr);
        mlaunch = 0; mpop = 0; mstall = 0;
      end
      1: if (lp == NW) mstate = 2;
      2: if (pp == NW) mstate = 3;
      default: mstate = 0;
    endcase
  endtask

  task automatic step();
    bit mir;
    logic [15:0] prod;
    mir = m_in_ready();
    chk("in_ready", in_ready, mir);
    chk("out_valid", out_valid, fq.size() > 0);
    chk("busy", busy, mstate == 1 || mstate == 2);
    chk("done", done, mstate == 3);
    if (fq.size() > 0) begin
      chk("out_data", out_data, fq[0]);
      chk("out_addr", out_addr, (mbase + mpop) % 512);
    end
`ifdef VECMAT_ADD_SEQ_PERF_EN
    chk("stall_cnt", stall_cnt, mstall);
`endif
    if (out_valid && out_ready) pop_addr.push_back(int'(out_addr));
    if (done) n_done++;
    if (in_valid && in_ready) n_launch++;
    prod = 16'($urandom);
    if (pq_age.size() > 0 && pq_age[0] == LAT - 1) tree_sum = pq_val[0];
    else tree_sum = 16'($urandom);
    @(posedge clk);
    model_update(mir, prod);
    @(negedge clk);
  endtask

  task automatic begin_job(input int base);
    pop_addr.delete();
    n_done = 0;
    n_launch = 0;
    base_addr = AW'(base);
    start = 1'b1;
    in_valid = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int pin, input int pout,
                           input string tag);
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(99) < pin);
      out_ready = ($urandom_range(99) < pout);
      step();
      if (n_done > 0) break;
    end
    in_valid = 1'b0;
    chk({tag, "_done_seen"}, n_done, 1);
  endtask

  function automatic int pa(input int i);
    return (pop_addr.size() > i) ? pop_addr[i] : -1;
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; base_addr = '0; tree_sum = '0;
    n_done = 0; n_launch = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);

    // full-throughput job
    begin_job(0);
    wait_done(100, 100, "s1");
    chk("s1_busy_after", busy, 0);
    chk("s1_pops", pop_addr.size(), 32);
    chk("s1_addr0", pa(0), 0);
    chk("s1_addr31", pa(31), 31);
    repeat (4) step();
    chk("s1_done_once", n_done, 1);

    // backpressure fills the FIFO
    begin_job(0);
    in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (20) step();
    chk("s2_launches", n_launch, 4);
    chk("s2_in_ready", in_ready, 0);
    chk("s2_out_valid", out_valid, 1);
    wait_done(100, 100, "s2");
    chk("s2_pops", pop_addr.size(), 32);
    chk("s2_addr31", pa(31), 31);

    // address wrap
    begin_job(500);
    wait_done(70, 70, "s3");
    chk("s3_addr0", pa(0), 500);
    chk("s3_addr11", pa(11), 511);
    chk("s3_addr12", pa(12), 0);
    chk("s3_addr31", pa(31), 19);

    // reset mid-job
    begin_job(0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && n_launch < 10; i++) step();
    chk("s4_launches", n_launch, 10);
    reset = 1'b0;
    step();
    reset = 1'b1;
    in_valid = 1'b0;
    chk("s4_in_ready", in_ready, 0);
    chk("s4_out_valid", out_valid, 0);
    chk("s4_busy", busy, 0);
    chk("s4_out_data", out_data, 0);
    chk("s4_out_addr", out_addr, 0);
    repeat (10) step();
    chk("s4_no_done", n_done, 0);
    begin_job(0);
    wait_done(100, 100, "s4b");
    chk("s4b_pops", pop_addr.size(), 32);
    chk("s4b_addr31", pa(31), 31);

    // start during RUN ignored
    begin_job(100);
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();
    base_addr = AW'(300);
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    wait_done(80, 80, "s5");
    chk("s5_pops", pop_addr.size(), 32);
    chk("s5_addr0", pa(0), 100);
    chk("s5_addr31", pa(31), 131);

    // random jobs
    for (int j = 0; j < 6; j++) begin
      begin_job(int'($urandom_range(511)));
      wait_done(int'($urandom_range(30, 100)),
                int'($urandom_range(30, 100)), "rnd");
      chk("rnd_pops", pop_addr.size(), 32);
      repeat (int'($urandom_range(0, 3))) step();
    end

`ifdef VECMAT_ADD_SEQ_PERF_EN
    begin
      int sb;
      sb = 5;
      begin_job(7);
      for (int i = 0; i < 600; i++) begin
        in_valid = m_in_ready();
        if (fq.size() > 0 && sb > 0) begin
          out_ready = 1'b0;
          sb--;
        end else begin
          out_ready = 1'b1;
        end
        step();
        if (n_done > 0) break;
      end
      in_valid = 1'b0;
      chk("s7_done_seen", n_done, 1);
      chk("s7_stall_cnt", stall_cnt, 5);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vecmat_add_seq.md
VECMAT_ADD_SEQ -- requirements
Module: vecmat_add_seq

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 32: vectors (words) summed per job.
REQ-002 SHALL have parameter TREE_LAT, default 2: adder-tree latency in cycles from product launch to valid sum.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: result FIFO entries (power of two).
REQ-004 SHALL have parameter ADDR_W, default 9: output-RAM address width (512 entries).
REQ-005 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port start, input, 1: job start pulse.
REQ-008 SHALL have port base_addr, input, ADDR_W: first output-RAM address of the job.
REQ-009 SHALL have port in_valid, input, 1: product vector presented to the adder tree.
REQ-010 SHALL have port in_ready, output, 1: controller accepts/launches the product this cycle.
REQ-011 SHALL have port tree_sum, input, 16: adder-tree 16-bit fixed-point result.
REQ-012 SHALL have port out_valid, output, 1: FIFO head valid.
REQ-013 SHALL have port out_ready, input, 1: downstream RAM writer accepts head.
REQ-014 SHALL have port out_data, output, 16: FIFO head sum.
REQ-015 SHALL have port out_addr, output, ADDR_W: RAM address of FIFO head.
REQ-016 SHALL have ports busy and done, output, 1 each: job active; one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start, RUN->DRAIN when launch count reaches NUM_WORDS, DRAIN->DONE when pop count reaches NUM_WORDS, DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL latch base_addr and clear launch/pop counters on IDLE->RUN; start outside IDLE SHALL be ignored.
REQ-019 SHALL drive in_ready = (state==RUN) && launch_cnt<NUM_WORDS && (inflight+fifo_count)<FIFO_DEPTH, so the non-stallable tree never overruns the FIFO.
REQ-020 SHALL count a launch on in_valid&&in_ready and shift a 1 into a TREE_LAT-deep valid pipe; 0 otherwise.
REQ-021 SHALL push tree_sum into the FIFO in the cycle the valid pipe's last stage is 1 (exactly TREE_LAT cycles after launch).
REQ-022 SHALL pop on out_valid&&out_ready; out_addr = latched base + pop_cnt, modulo 2^ADDR_W (wraps 511->0).
REQ-023 SHALL handle simultaneous push and pop in one cycle with fifo_count unchanged, including at full and empty.
REQ-024 SHALL hold out_data/out_addr stable while out_valid && !out_ready.
REQ-025 SHALL assert busy in RUN and DRAIN; done only in DONE.
REQ-026 SHALL retain in_ready low in DRAIN, DONE and IDLE; in_valid then is not consumed.

Reset
REQ-027 SHALL, when reset==0 at a clock edge, enter IDLE, clear counters, valid pipe and FIFO pointers; in_ready, out_valid, busy, done = 0; out_data = 0; out_addr = 0.
REQ-028 SHALL abort any in-flight job on reset mid-operation with no further push, pop or done.

Configuration
REQ-029 SHALL provide macro VECMAT_ADD_SEQ_PERF_EN; when defined, add output stall_cnt[15:0], cleared on start/reset, incrementing (saturating at 16'hFFFF) each busy cycle with in_valid&&!in_ready or out_valid&&!out_ready.
REQ-030 SHALL omit stall_cnt port and logic when VECMAT_ADD_SEQ_PERF_EN is undefined; all other behaviour identical.

Verification
REQ-031 SHALL cover: base_addr=0, in_valid and out_ready held 1 -> 32 pushes, sums at addr 0..31 in order, done pulse exactly once, busy low next cycle.
REQ-032 SHALL cover: out_ready=0 throughout -> in_ready drops after 4 launches, FIFO holds 4 entries, no loss; release -> remaining 28 complete.
REQ-033 SHALL cover: base_addr=500 -> addresses 500..511 then 0..19.
REQ-034 SHALL cover: reset=0 pulsed after 10 launches -> all outputs 0, no done; new start runs full 32-word job correctly.
REQ-035 SHALL cover: start asserted during RUN -> ignored, base_addr unchanged, counts unaffected.
REQ-036 SHALL cover (PERF_EN): out_ready low 5 busy cycles with FIFO valid -> stall_cnt=5 after job.
